// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational next-PC lookup for fetch,
// trained on the clock by resolved EX-stage branches.
//
// Ports:
//   Clk, Reset    posedge clock; async active-high reset clears the table
//   PC            current fetch address (from PC register)
//   NextAddress   predicted next fetch address (to PC register input)
//   PredHit       valid entry with matching tag for PC
//   PredTaken     PredHit and counter predicts taken
//   UpdateValid   resolved branch present this cycle
//   UpdatePC      address of the resolved branch
//   UpdateTaken   actual branch outcome
//   UpdateTarget  actual taken target
module branch_target_buffer #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  output logic [31:0] NextAddress,
  output logic        PredHit,
  output logic        PredTaken,
  input  logic        UpdateValid,
  input  logic [31:0] UpdatePC,
  input  logic        UpdateTaken,
  input  logic [31:0] UpdateTarget
);

  localparam int N = 1 << IDX_W;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [N-1:0]     valid_q;
  logic [TAG_W-1:0] tag_q    [N];
  logic [31:0]      target_q [N];
  logic [1:0]       ctr_q    [N];

  // Byte offset bits never take part in indexing or tagging.
  logic unused_lowbits;
  assign unused_lowbits = ^{PC[1:0], UpdatePC[1:0]};

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [31:0]      pc_plus4;

  assign l_idx    = PC[IDX_W+1:2];
  assign l_tag    = PC[31:IDX_W+2];
  assign pc_plus4 = PC + 32'd4;

  // Reset gates the outputs so the miss is seen the instant Reset rises,
  // independent of how the cleared flops propagate.
  always_comb begin
    PredHit     = 1'b0;
    PredTaken   = 1'b0;
    NextAddress = pc_plus4;
    if (!Reset && valid_q[l_idx] && (tag_q[l_idx] == l_tag)) begin
      PredHit   = 1'b1;
      PredTaken = ctr_q[l_idx][1];
    end
    if (PredTaken) begin
      NextAddress = target_q[l_idx];
    end
  end

  // ---------------- training ----------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [1:0]       u_ctr;

  assign u_idx = UpdatePC[IDX_W+1:2];
  assign u_tag = UpdatePC[31:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_ctr = ctr_q[u_idx];

  logic             we_d;
  logic [TAG_W-1:0] tag_d;
  logic [31:0]      target_d;
  logic [1:0]       ctr_d;

  always_comb begin
    we_d     = 1'b0;
    tag_d    = tag_q[u_idx];
    target_d = target_q[u_idx];
    ctr_d    = u_ctr;
    if (UpdateValid) begin
      if (u_hit) begin
        we_d = 1'b1;
        if (UpdateTaken) begin
          target_d = UpdateTarget;
          ctr_d    = (u_ctr == CTR_ST) ? CTR_ST : u_ctr + 2'd1;
        end else begin
          ctr_d    = (u_ctr == CTR_SNT) ? CTR_SNT : u_ctr - 2'd1;
        end
      end else if (UpdateTaken) begin
        // Allocate or evict the aliasing entry, starting weakly taken.
        we_d     = 1'b1;
        tag_d    = u_tag;
        target_d = UpdateTarget;
        ctr_d    = CTR_WT;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (we_d) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= tag_d;
      target_q[u_idx] <= target_d;
      ctr_q[u_idx]    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: vector table applied through a scoreboard
// queue, plus hand sequences for reset during operation.
module tb_branch_target_buffer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PC;
  logic [31:0] NextAddress;
  logic        PredHit;
  logic        PredTaken;
  logic        UpdateValid;
  logic [31:0] UpdatePC;
  logic        UpdateTaken;
  logic [31:0] UpdateTarget;

  int total = 0;
  int bad   = 0;

  branch_target_buffer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PC           (PC),
    .NextAddress  (NextAddress),
    .PredHit      (PredHit),
    .PredTaken    (PredTaken),
    .UpdateValid  (UpdateValid),
    .UpdatePC     (UpdatePC),
    .UpdateTaken  (UpdateTaken),
    .UpdateTarget (UpdateTarget)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] pc;
    logic        hit;
    logic        tk;
    logic [31:0] nxt;
  } vec_t;

  typedef struct {
    int          id;
    logic        hit;
    logic        tk;
    logic [31:0] nxt;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic h, input logic t,
                         input logic [31:0] n);
    chk({nm, ".hit"}, {31'd0, PredHit}, {31'd0, h});
    chk({nm, ".taken"}, {31'd0, PredTaken}, {31'd0, t});
    chk({nm, ".next"}, NextAddress, n);
  endtask

  task automatic add(input logic uv, input logic [31:0] upc,
                     input logic ut, input logic [31:0] utgt,
                     input logic [31:0] pc, input logic h,
                     input logic t, input logic [31:0] n);
    vec_t v;
    v = '{uv, upc, ut, utgt, pc, h, t, n};
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    Reset        = 1'b1;
    PC           = 32'h0000_0040;
    UpdateValid  = 1'b0;
    UpdatePC     = '0;
    UpdateTaken  = 1'b0;
    UpdateTarget = '0;

    // Expected outputs are those seen before the same row's update lands.
    add(0, 0,            0, 0,            32'h40,       0, 0, 32'h44);
    add(0, 0,            0, 0,            32'hFFFFFFFC, 0, 0, 32'h0);
    add(1, 32'h40,       1, 32'h100,      32'h40,       0, 0, 32'h44);
    add(0, 0,            0, 0,            32'h40,       1, 1, 32'h100);
    add(1, 32'h40,       0, 0,            32'h40,       1, 1, 32'h100);
    add(1, 32'h40,       0, 0,            32'h40,       1, 0, 32'h44);
    add(1, 32'h40,       0, 0,            32'h40,       1, 0, 32'h44);
    add(0, 0,            0, 0,            32'h40,       1, 0, 32'h44);
    add(1, 32'h40,       1, 32'h200,      32'h40,       1, 0, 32'h44);
    add(1, 32'h40,       1, 32'h300,      32'h40,       1, 0, 32'h44);
    add(0, 0,            0, 0,            32'h40,       1, 1, 32'h300);
    add(1, 32'h40,       1, 32'h300,      32'h40,       1, 1, 32'h300);
    add(1, 32'h40,       1, 32'h300,      32'h40,       1, 1, 32'h300);
    add(1, 32'h40,       0, 32'hDEAD0000, 32'h40,       1, 1, 32'h300);
    add(0, 0,            0, 0,            32'h40,       1, 1, 32'h300);
    add(1, 32'h80,       0, 32'h900,      32'h80,       0, 0, 32'h84);
    add(0, 0,            0, 0,            32'h80,       0, 0, 32'h84);
    add(1, 32'h440,      1, 32'h500,      32'h440,      0, 0, 32'h444);
    add(0, 0,            0, 0,            32'h40,       0, 0, 32'h44);
    add(0, 0,            0, 0,            32'h440,      1, 1, 32'h500);
    add(0, 0,            0, 0,            32'h442,      1, 1, 32'h500);
    add(1, 32'hFFFFFFFC, 1, 32'h10,       32'hFFFFFFFC, 0, 0, 32'h0);
    add(0, 0,            0, 0,            32'hFFFFFFFC, 1, 1, 32'h10);

    // Outputs under reset.
    @(negedge Clk);
    #1 chk_out("rst_40", 1'b0, 1'b0, 32'h44);
    PC = 32'hFFFFFFFC;
    #1 chk_out("rst_wrap", 1'b0, 1'b0, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int k = 0; k < vt.size(); k++) begin
      @(negedge Clk);
      UpdateValid  = vt[k].uv;
      UpdatePC     = vt[k].upc;
      UpdateTaken  = vt[k].ut;
      UpdateTarget = vt[k].utgt;
      PC           = vt[k].pc;
      sb.push_back('{k, vt[k].hit, vt[k].tk, vt[k].nxt});
      #2;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        chk_out($sformatf("vec%0d", e.id), e.hit, e.tk, e.nxt);
      end
    end

    // Reset raised mid-cycle drops the hit with no clock edge.
    @(negedge Clk);
    UpdateValid = 1'b0;
    PC          = 32'h440;
    #1 chk_out("pre_rst", 1'b1, 1'b1, 32'h500);
    #1 Reset = 1'b1;
    #1 chk_out("mid_rst", 1'b0, 1'b0, 32'h444);

    // Update coincident with reset is discarded.
    UpdateValid  = 1'b1;
    UpdatePC     = 32'h40;
    UpdateTaken  = 1'b1;
    UpdateTarget = 32'h100;
    @(negedge Clk);
    UpdateValid = 1'b0;
    Reset       = 1'b0;
    PC          = 32'h40;
    #1 chk_out("rst_upd", 1'b0, 1'b0, 32'h44);
    PC = 32'hFFFFFFFC;
    #1 chk_out("rst_clr", 1'b0, 1'b0, 32'h0);

    // Table is trainable again after reset.
    @(negedge Clk);
    UpdateValid  = 1'b1;
    UpdatePC     = 32'h44;
    UpdateTaken  = 1'b1;
    UpdateTarget = 32'h80;
    PC           = 32'h44;
    #1 chk_out("post_same", 1'b0, 1'b0, 32'h48);
    @(negedge Clk);
    UpdateValid = 1'b0;
    #1 chk_out("post_hit", 1'b1, 1'b1, 32'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
